// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm-game input path: debounce FSM encoding,
// clock rates and default debounce/hold timings used by several blocks.
package rhythm_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int unsigned CLK_HZ              = 32'd50000000;
  localparam int unsigned BEAT_HZ             = 32'd8;
  localparam int unsigned BEAT_DIV            = CLK_HZ / BEAT_HZ;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd250000;
  localparam int unsigned DEBOUNCE_CNT_W_DEF  = 32'd18;
  localparam int unsigned HOLD_CYCLES_DEF     = 32'd25000000;

  // Counts up to 255 and then sticks there.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (push-buttons, KEYs).
// RST_VAL selects the idle level held while in reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability-resolving shift pair.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hit_input_conditioner.sv
// Turns the raw active-low push-button into one clean hit per press, held until the next beat.
// Optional long-press detection is built when HOLD_DETECT_EN is defined.
module hit_input_conditioner
  import rhythm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button_n,
  input  logic       i_beat_tick,
  input  logic       i_clr,
  output logic       o_btn_level,
  output logic       o_press_pulse,
  output logic       o_hit_n,
  output logic       o_overrun,
  output logic [7:0] o_press_count,
  output logic       o_hold
);

  if ((DEBOUNCE_CYCLES < 32'd2) || (DEBOUNCE_CYCLES >= (32'd1 << CNT_W)) || (HOLD_CYCLES < 32'd1)) begin : g_bad_cfg
    $error("hit_input_conditioner: illegal DEBOUNCE_CYCLES/CNT_W/HOLD_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             w_s_n;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_btn_level;
  logic             w_level_nxt;
  logic             w_pulse_nxt;
  logic             r_press_pulse;
  logic             r_hit_pending;
  logic             r_overrun;
  logic [7:0]       r_press_count;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_button_n),
    .o_q   (w_s_n)
  );

  // Debounce FSM next state; the counter restarts on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_btn_level;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (!w_s_n) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_RELEASED;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_s_n) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (w_s_n) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_s_n) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  // Debounce FSM state and registered level/pulse outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RELEASED;
      r_cnt         <= '0;
      r_btn_level   <= 1'b0;
      r_press_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_btn_level   <= w_level_nxt;
      r_press_pulse <= w_pulse_nxt;
    end
  end

  // Pending hit: a press in the same cycle as a beat survives to the following beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit_pending <= 1'b0;
      r_overrun     <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      if (r_press_pulse) begin
        r_hit_pending <= 1'b1;
      end else if (i_beat_tick) begin
        r_hit_pending <= 1'b0;
      end else begin
        r_hit_pending <= r_hit_pending;
      end
      if (i_clr) begin
        r_overrun     <= 1'b0;
        r_press_count <= 8'd0;
      end else if (r_press_pulse) begin
        r_overrun     <= r_overrun | r_hit_pending;
        r_press_count <= sat_inc8(r_press_count);
      end else begin
        r_overrun     <= r_overrun;
        r_press_count <= r_press_count;
      end
    end
  end

`ifdef HOLD_DETECT_EN
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 32'd1);

  logic [31:0] r_hold_cnt;
  logic        r_hold;

  // Long-press timer counts HELD cycles only, so release bounces pause it rather than clear it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_cnt <= 32'd0;
      r_hold     <= 1'b0;
    end else if ((w_state_nxt == ST_RELEASED) || (w_state_nxt == ST_PRESS_WAIT)) begin
      r_hold_cnt <= 32'd0;
      r_hold     <= 1'b0;
    end else if (r_state == ST_HELD) begin
      if (r_hold_cnt == HOLD_LAST) begin
        r_hold <= 1'b1;
      end else begin
        r_hold_cnt <= r_hold_cnt + 32'd1;
      end
    end else begin
      r_hold_cnt <= r_hold_cnt;
      r_hold     <= r_hold;
    end
  end

  assign o_hold = r_hold;
`else
  assign o_hold = 1'b0;
`endif

  assign o_btn_level   = r_btn_level;
  assign o_press_pulse = r_press_pulse;
  assign o_hit_n       = ~r_hit_pending;
  assign o_overrun     = r_overrun;
  assign o_press_count = r_press_count;

endmodule

// File: doc/hit_input_conditioner.md
Name: hit_input_conditioner

Overview:
- Upstream of the rhythm-game datapath.
- Takes the raw, active-low push-button from the GPIO header and delivers one clean hit request per physical press.
- Steps: synchronise to CLOCK_50, debounce, edge-detect, then hold a pending-hit flag until the next 8 Hz beat strobe consumes it.
- The datapath samples the hit on the beat strobe. It sees exactly one low-level hit per press, never bounce or multi-beat repeats.

Parameters:
- DEBOUNCE_CYCLES, 250000: stable-low/stable-high cycles required to accept a level change (5 ms at 50 MHz). Legal range 2..2^CNT_W-1.
- CNT_W, 18: width of the debounce counter.
- HOLD_CYCLES, 25000000: cycles in HELD before long-press is flagged (0.5 s). Used only with HOLD_DETECT_EN.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  reset, asynchronous, active-high
- button_n  in  1  raw GPIO push-button, active-low, asynchronous to clk
- beat_tick  in  1  one-cycle 8 Hz strobe from clock_8hz; consumes a pending hit
- clr  in  1  synchronous clear of press_count and overrun (driven from the game-load key)
- btn_level  out  1  debounced level, 1 = pressed
- press_pulse  out  1  one-cycle strobe on each accepted press
- hit_n  out  1  active-low pending hit (~hit_pending); feeds the datapath button input
- overrun  out  1  sticky; a second press was accepted while a hit was still pending
- press_count  out  8  accepted presses since clr, saturating
- hold  out  1  long-press flag (HOLD_DETECT_EN only)

Behaviour:
- Reset (rst=1, async): sync flops=1, state RELEASED, counter=0, btn_level=0, press_pulse=0, hit_n=1, overrun=0, press_count=0, hold=0.
  - Reset mid-debounce or mid-hold discards all progress.
- Synchroniser: 2 flops on button_n, reset value 1. Only sync output s_n is used downstream.
- FSM, all outputs registered:
  - RELEASED: s_n=0 -> PRESS_WAIT, counter<=0.
  - PRESS_WAIT:
    - s_n=1 -> RELEASED (bounce rejected).
    - Else counter++.
    - counter==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, press_pulse<=1 for exactly one cycle.
  - HELD: s_n=1 -> RELEASE_WAIT, counter<=0.
  - RELEASE_WAIT:
    - s_n=0 -> HELD, with no new pulse.
    - Else counter++.
    - counter==DEBOUNCE_CYCLES-1 -> RELEASED, btn_level<=0.
- Latency: with button_n low and stable from edge 0, press_pulse is high in the cycle after edge DEBOUNCE_CYCLES+3. Release has the same latency.
- hit_pending:
  - Set on press_pulse. Cleared on beat_tick.
  - Simultaneous press_pulse and beat_tick: the set wins; the hit carries to the next beat.
  - press_pulse while hit_pending=1: hit_pending stays 1 and overrun<=1.
  - overrun is cleared only by clr or rst.
- press_count: +1 per press_pulse, saturates at 255.
  - clr has priority over an increment in the same cycle; result is 0.
- The counter never wraps. It is reset on every state entry, and terminal compare stops it.

Optional Feature:
- Macro: HOLD_DETECT_EN.
- Defined:
  - A second counter (32 bit) runs while in HELD.
  - hold<=1 when it reaches HOLD_CYCLES-1, and stays 1 until the FSM leaves HELD/RELEASE_WAIT for RELEASED.
  - A bounce into RELEASE_WAIT does not clear the hold counter.
- Undefined: hold tied 0, no hold counter, HOLD_CYCLES ignored.

Decomposition:
- Shared package rhythm_pkg holds:
  - the 2-bit FSM state encoding (RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT);
  - clock constants CLK_HZ=50000000 and BEAT_HZ=8;
  - default debounce/hold cycle constants, reused by clock_8hz and datapath.
- One natural sub-module, sync_2ff: a 2-flop synchroniser with a reset-value parameter, reusable for the KEY inputs.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20):
- Clean press: button_n 1->0 held 40 cycles -> press_pulse high one cycle at edge 7, btn_level=1, hit_n=0 until next beat_tick, press_count=1.
- Bounce reject: button_n low 2 cycles, high 2, repeated 5 times, then high -> no press_pulse, press_count=0, hit_n=1.
- Collision: beat_tick asserted in the same cycle as press_pulse -> hit_n stays 0; next beat_tick -> hit_n=1.
- Overrun and clear:
  - Two clean presses with no beat_tick between -> overrun=1, press_count=2, hit_n=0.
  - clr pulse -> overrun=0, press_count=0, hit_n still 0.
- Saturation and reset: 260 clean presses -> press_count=255. rst asserted mid PRESS_WAIT -> all outputs at reset values immediately, no pulse after release of rst.
- HOLD_DETECT_EN:
  - Press held 30 cycles -> hold=1 at 20 cycles after HELD entry.
  - Release -> hold=0 when btn_level falls.
  - Macro undefined -> hold constant 0.
